// File: rtl/code_word_packer_pkg.sv
// code_word_packer_pkg: shared stage-2 constants, length type and packer states
package code_word_packer_pkg;
  localparam int WORD_SIZE = 64;
  localparam int CACHE_LINE = 2 * WORD_SIZE;
  localparam int LEN_W = $clog2(WORD_SIZE) + 1;
  typedef logic [LEN_W-1:0] len_t;
  localparam len_t WORD_LEN = len_t'(WORD_SIZE);
  typedef enum logic [1:0] {PACK, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/code_word_packer_bit_appender.sv
// code_word_packer_bit_appender: masks a code, appends it above the fill point and flags word completion
module code_word_packer_bit_appender
  import code_word_packer_pkg::*;
(
  input  logic [CACHE_LINE-1:0] acc,
  input  len_t                  fill,
  input  logic [WORD_SIZE-1:0]  code,
  input  len_t                  length,
  output logic [CACHE_LINE-1:0] nxt,
  output len_t                  sum,
  output logic                  done,
  output logic                  len_err
);
  len_t len;
  logic [WORD_SIZE-1:0] masked;
  assign len_err = length > WORD_LEN;
  assign len = len_err ? WORD_LEN : length;
  assign masked = code & ~({WORD_SIZE{1'b1}} << len);
  assign nxt = acc | ({{WORD_SIZE{1'b0}}, masked} << fill);
  assign sum = fill + len;
  assign done = sum >= WORD_LEN;
endmodule

// File: rtl/code_word_packer.sv
// code_word_packer: packs variable-length codes LSB-first into two-word lines with flush and valid/ready output
module code_word_packer
  import code_word_packer_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [WORD_SIZE-1:0]  i_code,
  input  len_t                  i_length,
  input  logic                  i_flush,
  output logic                  o_ready,
  output logic                  o_line_valid,
  output logic [CACHE_LINE-1:0] o_line,
  output logic [7:0]            o_line_bits,
  input  logic                  i_line_ready,
  output logic                  o_flush_done,
  output logic                  o_len_err
);
  state_t state;
  logic [CACHE_LINE-1:0] acc, nxt;
  len_t fill, sum;
  logic [WORD_SIZE-1:0] word0;
  logic word_idx, done, len_err, free, accept;
  code_word_packer_bit_appender u_app (
    .acc(acc),
    .fill(fill),
    .code(i_code),
    .length(i_length),
    .nxt(nxt),
    .sum(sum),
    .done(done),
    .len_err(len_err)
  );
  assign free = !o_line_valid || i_line_ready;
  assign o_ready = (state == PACK) && free;
  assign accept = i_valid && o_ready;
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= PACK;
      acc <= '0;
      fill <= '0;
      word0 <= '0;
      word_idx <= 1'b0;
      o_line <= '0;
      o_line_bits <= '0;
      o_line_valid <= 1'b0;
      o_flush_done <= 1'b0;
      o_len_err <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      if (o_line_valid && i_line_ready) o_line_valid <= 1'b0;
      case (state)
        PACK: begin
          if (accept) begin
            o_len_err <= o_len_err | len_err;
            acc <= done ? nxt >> WORD_SIZE : nxt;
            fill <= done ? sum - WORD_LEN : sum;
            if (done) begin
              word_idx <= !word_idx;
              if (!word_idx) word0 <= nxt[WORD_SIZE-1:0];
              else begin
                o_line <= {nxt[WORD_SIZE-1:0], word0};
                o_line_bits <= 8'(CACHE_LINE);
                o_line_valid <= 1'b1;
              end
            end
          end
          if (o_ready && i_flush) state <= FLUSH;
        end
        FLUSH: if (free) begin
          if (word_idx || fill != '0) begin
            o_line <= word_idx ? {acc[WORD_SIZE-1:0], word0} : {{WORD_SIZE{1'b0}}, acc[WORD_SIZE-1:0]};
            o_line_bits <= {1'b0, word_idx ? WORD_LEN + fill : fill};
            o_line_valid <= 1'b1;
            acc <= '0;
            fill <= '0;
            word_idx <= 1'b0;
            state <= DRAIN;
          end else begin
            o_flush_done <= 1'b1;
            state <= PACK;
          end
        end
        default: if (o_line_valid && i_line_ready) begin
          o_flush_done <= 1'b1;
          state <= PACK;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_code_word_packer.sv
// tb_code_word_packer: vector table, corner sequences and randomized bit-queue scoreboard for code_word_packer
module tb_code_word_packer;
  logic clk = 1'b0;
  logic i_reset, i_valid, i_flush, i_line_ready;
  logic [63:0] i_code;
  logic [6:0] i_length;
  logic o_ready, o_line_valid, o_flush_done, o_len_err;
  logic [127:0] o_line;
  logic [7:0] o_line_bits;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  code_word_packer dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_code(i_code),
    .i_length(i_length),
    .i_flush(i_flush),
    .o_ready(o_ready),
    .o_line_valid(o_line_valid),
    .o_line(o_line),
    .o_line_bits(o_line_bits),
    .i_line_ready(i_line_ready),
    .o_flush_done(o_flush_done),
    .o_len_err(o_len_err)
  );
  typedef struct {
    logic v;
    logic [63:0] code;
    logic [6:0] len;
    logic fl;
    logic lr;
    logic rdy;
    logic vld;
    logic [127:0] line;
    logic [7:0] bits;
    logic done;
    logic err;
  } vec_t;
  typedef struct {
    logic [127:0] line;
    logic [7:0] bits;
  } line_t;
  vec_t tbl[$];
  bit mq[$];
  line_t exq[$];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic vec_t row(logic v, logic [63:0] code, logic [6:0] len, logic fl, logic lr,
                               logic rdy, logic vld, logic [127:0] line, logic [7:0] bits, logic done, logic err);
    vec_t r;
    r.v = v; r.code = code; r.len = len; r.fl = fl; r.lr = lr;
    r.rdy = rdy; r.vld = vld; r.line = line; r.bits = bits; r.done = done; r.err = err;
    return r;
  endfunction
  task automatic drive(input logic v, input logic [63:0] code, input logic [6:0] len, input logic fl, input logic lr);
    i_valid = v; i_code = code; i_length = len; i_flush = fl; i_line_ready = lr;
  endtask
  task automatic emit(input int n);
    line_t e;
    e.line = '0;
    e.bits = 8'(n);
    for (int k = 0; k < n; k++) e.line[k] = mq.pop_front();
    exq.push_back(e);
  endtask
  initial begin
    logic [63:0] ones, c5, rc;
    logic [127:0] l55, lones;
    int seen_valid, seen_done, flush_pending, len_i;
    logic err_model;
    line_t e;
    ones = '1;
    c5 = 64'hFFFF_FFFF_FFFF_FFF5;
    l55 = {64'h5, 64'h5};
    lones = '1;
    drive(0, '0, '0, 0, 0);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_line_valid, 0);
    chk("reset_done", o_flush_done, 0);
    chk("reset_err", o_len_err, 0);
    chk("reset_bits", o_line_bits, 0);
    @(negedge clk);
    // packing: 10+20+40+5+60 ones -> one full line, 7 bits left
    tbl.push_back(row(1, ones, 10, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, ones, 20, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, ones, 40, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, ones, 5, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, ones, 60, 0, 1, 1, 1, lones, 128, 0, 0));
    tbl.push_back(row(0, ones, 0, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 0, 0, 1, 128'h7F, 7, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 0, 0, 1, 128'h7F, 7, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 0, '0, 0, 0, 0));
    // empty flush
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 0, '0, 0, 0, 0));
    // masking and bit order
    tbl.push_back(row(1, c5, 4, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, '0, 60, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, c5, 4, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(1, '0, 60, 0, 1, 1, 1, l55, 128, 0, 0));
    // backpressure for five cycles, then same-cycle release
    for (int k = 0; k < 5; k++) tbl.push_back(row(1, ones, 10, 0, 0, 0, 1, l55, 128, 0, 0));
    tbl.push_back(row(1, ones, 4, 0, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 0, '0, 0, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 1, 128'hF, 4, 0, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 0, '0, 0, 0, 0));
    // oversize length clamps to a full word and sets the sticky error
    tbl.push_back(row(1, ones, 100, 0, 1, 1, 0, '0, 0, 0, 1));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 0, '0, 0, 0, 1));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 1, {64'h0, ones}, 64, 0, 1));
    tbl.push_back(row(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 1));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 0, '0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].code, tbl[i].len, tbl[i].fl, tbl[i].lr);
      #1;
      chk($sformatf("row%0d_ready", i), o_ready, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), o_line_valid, tbl[i].vld);
      chk($sformatf("row%0d_done", i), o_flush_done, tbl[i].done);
      chk($sformatf("row%0d_err", i), o_len_err, tbl[i].err);
      if (tbl[i].vld) begin
        chk($sformatf("row%0d_line", i), o_line, tbl[i].line);
        chk($sformatf("row%0d_bits", i), o_line_bits, tbl[i].bits);
      end
    end
    // reset with one word and a partial word pending discards everything
    drive(1, ones, 64, 0, 1);
    @(negedge clk);
    drive(1, ones, 10, 0, 1);
    @(negedge clk);
    drive(0, '0, 0, 0, 1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("midreset_valid", o_line_valid, 0);
    chk("midreset_err", o_len_err, 0);
    chk("midreset_ready", o_ready, 1);
    drive(0, '0, 0, 1, 1);
    @(negedge clk);
    drive(0, '0, 0, 0, 1);
    seen_valid = 0;
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen_valid += int'(o_line_valid);
      seen_done += int'(o_flush_done);
    end
    chk("midreset_no_line", 32'(seen_valid), 0);
    chk("midreset_flush_done", 32'(seen_done), 1);
    // randomized traffic against a bit-queue model
    flush_pending = 0;
    err_model = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      len_i = int'($urandom_range(0, 15));
      len_i = len_i == 0 ? 0 : len_i == 1 ? 64 : len_i == 2 ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
      rc = {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0, rc, 7'(len_i), $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      #1;
      if (o_line_valid && !i_line_ready) chk("rand_ready_blocked", o_ready, 0);
      if (o_line_valid && i_line_ready) begin
        if (exq.size() == 0) chk("rand_unexpected_line", o_line_bits, 0);
        else begin
          e = exq.pop_front();
          chk("rand_line", o_line, e.line);
          chk("rand_bits", o_line_bits, e.bits);
        end
      end
      if (o_ready) begin
        if (i_valid) begin
          if (len_i > 64) err_model = 1'b1;
          for (int k = 0; k < (len_i > 64 ? 64 : len_i); k++) mq.push_back(rc[k]);
          while (mq.size() >= 128) emit(128);
        end
        if (i_flush) begin
          if (mq.size() > 0) emit(mq.size());
          flush_pending++;
        end
      end
      @(negedge clk);
      chk("rand_err", o_len_err, err_model);
      if (o_flush_done) begin
        chk("rand_flush_done_expected", flush_pending > 0, 1);
        flush_pending--;
      end
    end
    drive(0, '0, 0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (o_line_valid) begin
        if (exq.size() == 0) chk("drain_unexpected_line", o_line_bits, 0);
        else begin
          e = exq.pop_front();
          chk("drain_line", o_line, e.line);
          chk("drain_bits", o_line_bits, e.bits);
        end
      end
      @(negedge clk);
      if (o_flush_done) flush_pending--;
    end
    chk("rand_lines_left", 32'(exq.size()), 0);
    chk("rand_flush_left", 32'(flush_pending), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/code_word_packer.md
Name: code_word_packer

Overview:
- Stage 2 compression datapath block that sits directly downstream of the length accumulator.
- Takes variable-length compressed codes (0..WORD_SIZE bits each) and concatenates them LSB-first into WORD_SIZE-bit words.
- Assembles two completed words into a CACHE_LINE-bit output line and hands it on with a valid/ready handshake.
- On flush, zero-pads the partial line and emits it.

Parameters:
- WORD_SIZE, 64, packing word width in bits.
- CACHE_LINE, 128, output line width in bits; must equal 2*WORD_SIZE.
- LEN_W, 7, code length field width, $clog2(WORD_SIZE)+1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  code present.
- i_code  in  WORD_SIZE  code bits; only bits [i_length-1:0] are used, upper bits are ignored.
- i_length  in  LEN_W  code length in bits, 0..WORD_SIZE.
- i_flush  in  1  end of block: pad and emit the partial line.
- o_ready  out  1  code/flush accepted this cycle when high.
- o_line_valid  out  1  output line held valid.
- o_line  out  CACHE_LINE  packed line; the first code sits in bit 0.
- o_line_bits  out  8  number of meaningful bits in o_line (1..128).
- i_line_ready  in  1  consumer accepts the line.
- o_flush_done  out  1  one-cycle pulse when a flush has completed.
- o_len_err  out  1  sticky flag: some i_length exceeded WORD_SIZE.

Behaviour:
- Reset: every output is 0 except o_ready, which is 1 (state PACK). acc, fill, word0, word_idx and the state register are all cleared. Reset in the middle of a line discards all pending data.
- Internal state:
  - acc: 2*WORD_SIZE-bit register.
  - fill: 7-bit count; the invariant fill < WORD_SIZE holds between accepts.
  - word0: first completed word of the current line.
  - word_idx: 0 or 1.
- Accept condition: i_valid && o_ready.
- On accept:
  - len = min(i_length, WORD_SIZE). If i_length > WORD_SIZE, set o_len_err.
  - masked = i_code with bits at position ≥ len cleared.
  - nxt = acc | (masked << fill); sum = fill + len.
  - If sum ≥ WORD_SIZE, a word completes: the word is nxt[WORD_SIZE-1:0], acc <= nxt >> WORD_SIZE, fill <= sum - WORD_SIZE.
  - Otherwise acc <= nxt and fill <= sum.
  - len = 0 is a no-op accept.
- Word completion:
  - If word_idx = 0: word0 <= word, word_idx <= 1.
  - If word_idx = 1: o_line <= {word, word0}, o_line_bits <= 128, o_line_valid <= 1 on the next cycle, word_idx <= 0.
- Latency: the line becomes valid the cycle after the accept that completes the second word.
- Output handshake:
  - o_line_valid stays high, and o_line/o_line_bits stay stable, until i_line_ready is sampled high.
  - A new line may load in the same cycle the old one is accepted (back-to-back lines, no bubble).
- o_ready = (state == PACK) && (!o_line_valid || i_line_ready). This is a combinational path from i_line_ready, and it is intended.
- State machine:
  - PACK:
    - Normal packing.
    - If i_flush is high while o_ready is high, go to FLUSH.
    - If i_valid and i_flush are both high in that cycle, the code is accepted and packed first.
  - FLUSH:
    - Waits for the output register to be free (!o_line_valid || i_line_ready).
    - If word_idx = 1 or fill > 0: o_line <= zero-padded {acc[WORD_SIZE-1:0], word0}, with the acc bits taking word0's position when word_idx = 0. Set o_line_bits <= word_idx*WORD_SIZE + fill and o_line_valid <= 1. Clear acc, fill and word_idx. Go to DRAIN.
    - If nothing is pending: pulse o_flush_done on the next cycle and go to PACK.
  - DRAIN: when the line handshake completes, pulse o_flush_done for one cycle and go to PACK.
- Boundaries:
  - A code with len = WORD_SIZE at fill = 0 completes a word exactly, leaving fill = 0.
  - The maximum sum is 127, so 7 bits suffice.
  - Padding bits are always 0.
  - o_len_err is cleared only by reset.

Decomposition:
- Shared stage-2 package holds:
  - WORD_SIZE and CACHE_LINE constants.
  - Length type logic [6:0].
  - State enum {PACK, FLUSH, DRAIN}.
- One sub-module, bit_appender: the combinational mask/shift/OR plus sum and word-complete detection.
- The top level keeps the registers, the FSM and the handshake logic.

Test Plan:
- Reset: assert i_reset for 2 cycles, then release → o_ready = 1, o_line_valid = 0, o_flush_done = 0, o_len_err = 0.
- Packing: i_code = all-ones, lengths 10, 20, 40, 5, 60, i_line_ready = 1 →
  - one line with o_line = all-ones and o_line_bits = 128, valid the cycle after the 60-bit accept;
  - a residue of 7 bits remains.
- Masking/order: length 4 code 64'hFFFF_FFFF_FFFF_FFF5, then length 60 code 0, repeated twice → o_line = 128'h0..050..05 (bits [3:0] = 4'h5 in each word).
- Backpressure: hold i_line_ready = 0 while a line is pending →
  - o_ready = 0 and o_line stays stable for 5 cycles;
  - raising i_line_ready gives a one-cycle handshake, with o_ready = 1 in the same cycle.
- Flush with residue: 7 pending bits, pulse i_flush → line with o_line_bits = 7, o_line[127:7] = 0, then o_flush_done pulses after acceptance.
- Edge cases:
  - Empty flush → o_flush_done pulse and no line.
  - i_length = 100 → treated as 64 and o_len_err = 1.
  - i_reset asserted with one word pending → no line is emitted afterwards.
